red_seq_reducer: RTL and testbench



---
 rtl/red_pkg.sv | 24 ++
 rtl/red_lane_pair_add.sv | 20 ++
 rtl/red_seq_reducer.sv | 142 ++++++++++++++
 tb/tb_red_seq_reducer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/red_pkg.sv
// Shared types and constant helpers for the serial lane-sum reducer.
// Build option RED_SAT_EN (used by red_seq_reducer) selects clamping over wrap-around narrowing.
package red_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } red_state_e;

    // Accumulator width that cannot overflow when summing 2*lanes signed lanes.
    function automatic int acc_width(input int lane_w, input int lanes);
        return lane_w + $clog2(2 * lanes);
    endfunction

    function automatic int sat_max(input int res_w);
        return (1 << (res_w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int res_w);
        return -(1 << (res_w - 1));
    endfunction

endpackage

// File: rtl/red_lane_pair_add.sv
// Sign-extends one lane from each operand and adds both to the running accumulator.
// Purely combinational, single ACC_W-bit add.
module red_lane_pair_add #(
    parameter int LANE_W = 4,
    parameter int ACC_W  = 7
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    input  logic        [LANE_W-1:0] lane_a_i,
    input  logic        [LANE_W-1:0] lane_b_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    logic signed [ACC_W-1:0] ext_a;
    logic signed [ACC_W-1:0] ext_b;

    assign ext_a = {{(ACC_W-LANE_W){lane_a_i[LANE_W-1]}}, lane_a_i};
    assign ext_b = {{(ACC_W-LANE_W){lane_b_i[LANE_W-1]}}, lane_b_i};
    assign acc_o = acc_i + ext_a + ext_b;

endmodule

// File: rtl/red_seq_reducer.sv
// Serial signed lane-sum reducer: one lane pair per cycle, result narrowed to RES_W and sign-extended.
// Build option RED_SAT_EN: clamp on out-of-range sums; otherwise wrap. Result held until out_ready.
module red_seq_reducer
    import red_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANE_W = 4,
    parameter int RES_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum,
    output logic              sat_flag
);

    localparam int LANES = DATA_W / LANE_W;
    localparam int ACC_W = acc_width(LANE_W, LANES);
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    red_state_e              state_q, state_d;
    logic [DATA_W-1:0]       a_q, a_d;
    logic [DATA_W-1:0]       b_q, b_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_W-1:0]       sum_q, sum_d;
    logic                    sat_q, sat_d;

    logic [LANE_W-1:0]       lane_a;
    logic [LANE_W-1:0]       lane_b;
    logic signed [ACC_W-1:0] acc_add;
    int                      acc_int;
    logic                    sat_now;
    logic signed [RES_W-1:0] res_narrow;
    logic                    last_lane;

    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int i = 0; i < LANES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                lane_a = a_q[i*LANE_W +: LANE_W];
                lane_b = b_q[i*LANE_W +: LANE_W];
            end
        end
    end

    red_lane_pair_add #(
        .LANE_W (LANE_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc_i    (acc_q),
        .lane_a_i (lane_a),
        .lane_b_i (lane_b),
        .acc_o    (acc_add)
    );

    // Narrowing looks at the post-add value so the final lane is included.
    always_comb begin
        acc_int = int'(acc_add);
        sat_now = (acc_int > sat_max(RES_W)) || (acc_int < sat_min(RES_W));
`ifdef RED_SAT_EN
        if (sat_now) begin
            res_narrow = (acc_int > 0) ? RES_W'(sat_max(RES_W)) : RES_W'(sat_min(RES_W));
        end else begin
            res_narrow = RES_W'(acc_int);
        end
`else
        res_narrow = RES_W'(acc_int);
`endif
    end

    assign last_lane = (idx_q == IDX_W'(LANES - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        sat_d   = sat_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                acc_d = acc_add;
                idx_d = idx_q + 1'b1;
                if (last_lane) begin
                    idx_d   = '0;
                    sum_d   = DATA_W'(int'(res_narrow));
                    sat_d   = sat_now;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            sat_q   <= sat_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_red_seq_reducer.sv
// Directed and randomized checks of red_seq_reducer against an arithmetic lane-sum model.
module tb_red_seq_reducer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        sat_flag;

    int n_cmp  = 0;
    int n_fail = 0;

    red_seq_reducer #(
        .DATA_W (16),
        .LANE_W (4),
        .RES_W  (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: true sum of all signed 4-bit lanes, then 6-bit narrowing.
    task automatic model(input logic [15:0] av, input logic [15:0] bv,
                         output logic [15:0] exp_s, output logic exp_sat);
        int total;
        int v;
        int r;
        total = 0;
        for (int i = 0; i < 4; i++) begin
            v = int'(av[4*i +: 4]);
            if (v > 7) v -= 16;
            total += v;
            v = int'(bv[4*i +: 4]);
            if (v > 7) v -= 16;
            total += v;
        end
        exp_sat = (total > 31) || (total < -32);
`ifdef RED_SAT_EN
        r = exp_sat ? ((total > 0) ? 31 : -32) : total;
`else
        r = total & 63;
        if (r > 31) r -= 64;
`endif
        exp_s = 16'(r);
    endtask

    task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] exp_s, input logic exp_sat, input int hold);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            a = 16'($urandom);
            b = 16'($urandom);
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_sum"}, 32'(sum), 32'(exp_s));
        check({tag, "_sat"}, 32'(sat_flag), 32'(exp_sat));
        check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                a = 16'($urandom);
                b = 16'($urandom);
                in_valid = 1'b1;
            end
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_sum"}, 32'(sum), 32'(exp_s));
            check({tag, "_hold_sat"}, 32'(sat_flag), 32'(exp_sat));
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_release_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_release_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] ra, rb, es;
        logic        esat;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_sat", 32'(sat_flag), 32'd0);
        rst = 1'b0;

        do_op("basic", 16'h1234, 16'h1111, 16'h000E, 1'b0, 0);
`ifdef RED_SAT_EN
        do_op("pos_ovf", 16'h7777, 16'h7777, 16'h001F, 1'b1, 0);
        do_op("neg_ovf", 16'h8888, 16'h8888, 16'hFFE0, 1'b1, 0);
`else
        do_op("pos_ovf", 16'h7777, 16'h7777, 16'hFFF8, 1'b1, 0);
        do_op("neg_ovf", 16'h8888, 16'h8888, 16'h0000, 1'b1, 0);
`endif
        do_op("neg_in_range", 16'hFFFF, 16'h0000, 16'hFFFC, 1'b0, 0);
        do_op("backpressure", 16'h1234, 16'h1111, 16'h000E, 1'b0, 10);

        // Leave a nonzero result, then reset during the 2nd ACCUM cycle.
        do_op("pre_reset", 16'hFFFF, 16'h0000, 16'hFFFC, 1'b0, 0);
        @(negedge clk);
        a = 16'h7777;
        b = 16'h7777;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_sat", 32'(sat_flag), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst_no_pulse", 32'(out_valid), 32'd0);
        do_op("post_reset", 16'h1234, 16'h1111, 16'h000E, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            model(ra, rb, es, esat);
            do_op("rand", ra, rb, es, esat, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
